// File: rtl/param_data_memory.sv
// param_data_memory: word-addressed data memory with valid/ready requests,
// per-byte write strobes, 1- or 2-cycle read latency, an out-of-range error
// pulse and an optional zero-fill sweep after reset.
module param_data_memory #(
  parameter int DATA_WIDTH     = 32,
  parameter int DEPTH          = 65536,
  parameter int READ_LATENCY   = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                    clock,
  input  logic                    reset_n,
  input  logic                    req_valid,
  output logic                    req_ready,
  input  logic                    req_write,
  input  logic [31:0]             req_addr,
  input  logic [DATA_WIDTH-1:0]   req_wdata,
  input  logic [DATA_WIDTH/8-1:0] req_wstrb,
  output logic                    rvalid,
  output logic [DATA_WIDTH-1:0]   rdata,
  output logic                    err,
  output logic                    busy
);
  localparam int NB = DATA_WIDTH / 8;
  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam logic [AW-1:0] IDX_LAST = AW'(DEPTH - 1);
  // One extra bit so the range compare never wraps, whatever DEPTH is.
  localparam logic [32:0] DEPTH_EXT = 33'(DEPTH);

  typedef enum logic {S_CLEAR, S_RUN} state_t;
  localparam state_t RESET_STATE = (CLEAR_ON_RESET != 0) ? S_CLEAR : S_RUN;
  localparam logic   RESET_BUSY  = (CLEAR_ON_RESET != 0);

  logic [DATA_WIDTH-1:0] mem [DEPTH];

  state_t  state_q, state_d;
  logic [AW-1:0] idx_q, idx_d;
  logic    ready_q, ready_d;
  logic    busy_q, busy_d;

  logic          acc, rd_acc, wr_acc, in_range;
  logic [AW-1:0] addr_idx;
  logic signed [DATA_WIDTH-1:0] rd_word;

  logic                  mem_we;
  logic [AW-1:0]         mem_waddr;
  logic [DATA_WIDTH-1:0] mem_wdata;
  logic [NB-1:0]         mem_wstrb;

  logic vld_p1_q, vld_p1_d;
  logic oor_p1_q, oor_p1_d;
  logic wrerr_p1_q, wrerr_p1_d;
  logic signed [DATA_WIDTH-1:0] data_p1_q, data_p1_d;

  assign req_ready = ready_q;
  assign busy      = busy_q;

  // Request decode: acceptance, range check and the asynchronous array read.
  always_comb begin
    acc      = req_valid && ready_q;
    rd_acc   = acc && !req_write;
    wr_acc   = acc && req_write;
    in_range = ({1'b0, req_addr} < DEPTH_EXT);
    addr_idx = req_addr[AW-1:0];
    rd_word  = mem[addr_idx];
  end

  // Sweep/run sequencing; ready and busy are registered with the state.
  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    ready_d = ready_q;
    busy_d  = busy_q;
    case (state_q)
      S_CLEAR: begin
        ready_d = 1'b0;
        busy_d  = 1'b1;
        if (idx_q == IDX_LAST) begin
          state_d = S_RUN;
          ready_d = 1'b1;
          busy_d  = 1'b0;
        end else begin
          idx_d = idx_q + 1'b1;
        end
      end
      default: begin
        ready_d = 1'b1;
        busy_d  = 1'b0;
      end
    endcase
  end

  // Array write port is shared by the clear sweep and accepted in-range writes.
  always_comb begin
    mem_we    = 1'b0;
    mem_waddr = addr_idx;
    mem_wdata = req_wdata;
    mem_wstrb = req_wstrb;
    if (state_q == S_CLEAR) begin
      mem_we    = 1'b1;
      mem_waddr = idx_q;
      mem_wdata = '0;
      mem_wstrb = '1;
    end else if (wr_acc && in_range) begin
      mem_we = 1'b1;
    end
  end

  // ---- p1: response captured at the accepting edge
  always_comb begin
    vld_p1_d   = rd_acc;
    oor_p1_d   = rd_acc && !in_range;
    wrerr_p1_d = wr_acc && !in_range;
    data_p1_d  = data_p1_q;
    if (rd_acc) data_p1_d = in_range ? rd_word : '0;
  end

  // Control and response registers; reset drops any read still in flight.
  always_ff @(posedge clock or negedge reset_n) begin
    if (!reset_n) begin
      state_q    <= RESET_STATE;
      idx_q      <= '0;
      ready_q    <= 1'b0;
      busy_q     <= RESET_BUSY;
      vld_p1_q   <= 1'b0;
      oor_p1_q   <= 1'b0;
      wrerr_p1_q <= 1'b0;
      data_p1_q  <= '0;
    end else begin
      state_q    <= state_d;
      idx_q      <= idx_d;
      ready_q    <= ready_d;
      busy_q     <= busy_d;
      vld_p1_q   <= vld_p1_d;
      oor_p1_q   <= oor_p1_d;
      wrerr_p1_q <= wrerr_p1_d;
      data_p1_q  <= data_p1_d;
    end
  end

  // Storage array: byte-masked write, contents untouched by reset.
  always_ff @(posedge clock) begin
    if (mem_we) begin
      for (int b = 0; b < NB; b++) begin
        if (mem_wstrb[b]) mem[mem_waddr][8*b +: 8] <= mem_wdata[8*b +: 8];
      end
    end
  end

  if (READ_LATENCY == 2) begin : g_lat2
    logic vld_p2_q, vld_p2_d;
    logic oor_p2_q, oor_p2_d;
    logic signed [DATA_WIDTH-1:0] data_p2_q, data_p2_d;

    // ---- p2: one extra cycle of read latency; rdata holds between responses
    always_comb begin
      vld_p2_d  = vld_p1_q;
      oor_p2_d  = oor_p1_q;
      data_p2_d = vld_p1_q ? data_p1_q : data_p2_q;
    end

    // Second response stage registers.
    always_ff @(posedge clock or negedge reset_n) begin
      if (!reset_n) begin
        vld_p2_q  <= 1'b0;
        oor_p2_q  <= 1'b0;
        data_p2_q <= '0;
      end else begin
        vld_p2_q  <= vld_p2_d;
        oor_p2_q  <= oor_p2_d;
        data_p2_q <= data_p2_d;
      end
    end

    assign rvalid = vld_p2_q;
    assign rdata  = data_p2_q;
    // Write errors always report one cycle after accept, reads at full latency.
    assign err    = wrerr_p1_q | oor_p2_q;
  end else begin : g_lat1
    assign rvalid = vld_p1_q;
    assign rdata  = data_p1_q;
    assign err    = wrerr_p1_q | oor_p1_q;
  end

endmodule
